// File: rtl/tracker_pkg.sv
// Shared tracker definitions: note codes, command layout and the command packing helper.
package tracker_pkg;

    localparam logic [3:0] NOTE_C         = 4'd0;
    localparam logic [3:0] NOTE_CS        = 4'd1;
    localparam logic [3:0] NOTE_D         = 4'd2;
    localparam logic [3:0] NOTE_DS        = 4'd3;
    localparam logic [3:0] NOTE_E         = 4'd4;
    localparam logic [3:0] NOTE_F         = 4'd5;
    localparam logic [3:0] NOTE_FS        = 4'd6;
    localparam logic [3:0] NOTE_G         = 4'd7;
    localparam logic [3:0] NOTE_GS        = 4'd8;
    localparam logic [3:0] NOTE_A         = 4'd9;
    localparam logic [3:0] NOTE_AS        = 4'd10;
    localparam logic [3:0] NOTE_B         = 4'd11;
    localparam logic [3:0] NOTE_UNDEFINED = 4'hF;

    localparam logic [23:0] TRACK_END = 24'hFFFFFF;

    // Command field offsets
    localparam int unsigned CMD_END_BIT   = 23;
    localparam int unsigned CMD_DUR_LSB   = 12;
    localparam int unsigned CMD_OCT2_LSB  = 10;
    localparam int unsigned CMD_NOTE2_LSB = 6;
    localparam int unsigned CMD_OCT1_LSB  = 4;
    localparam int unsigned CMD_NOTE1_LSB = 0;

    // Last entry is reserved for the terminator; segments saturate at 32 ticks
    localparam logic [5:0] LAST_ADDR = 6'd63;
    localparam logic [5:0] SEG_MAX   = 6'd32;

    typedef enum logic [2:0] {
        StIdle,
        StWait,
        StNote,
        StRest,
        StFinish,
        StDone
    } rec_state_e;

    // Build a playable (non-terminator) command word
    function automatic logic [23:0] pack_cmd(input logic [4:0] dur,
                                             input logic [1:0] oct2,
                                             input logic [3:0] note2,
                                             input logic [1:0] oct1,
                                             input logic [3:0] note1);
        logic [23:0] cmd;
        cmd = '0;
        cmd[CMD_END_BIT]            = 1'b0;
        cmd[CMD_DUR_LSB   +: 5]     = dur;
        cmd[CMD_OCT2_LSB  +: 2]     = oct2;
        cmd[CMD_NOTE2_LSB +: 4]     = note2;
        cmd[CMD_OCT1_LSB  +: 2]     = oct1;
        cmd[CMD_NOTE1_LSB +: 4]     = note1;
        return cmd;
    endfunction

endpackage

// File: rtl/track_cmd_writer.sv
// One-entry valid/ready holding register for track commands plus the entry address counter.
module track_cmd_writer
    import tracker_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        push,
    input  logic [23:0] push_data,
    input  logic        wr_ready,
    output logic        wr_valid,
    output logic [5:0]  wr_addr,
    output logic [23:0] wr_data,
    output logic        can_push,
    output logic        accept,
    output logic        drop
);

    logic        valid_q;
    logic [23:0] data_q;
    logic [5:0]  addr_q;

    // A new command may load in the same cycle the held one is accepted
    always_comb begin
        accept   = valid_q && wr_ready;
        can_push = !valid_q || wr_ready;
        drop     = push && !can_push;
        wr_valid = valid_q;
        wr_addr  = addr_q;
        wr_data  = data_q;
    end

    // Holding register and address counter
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            addr_q  <= '0;
        end else begin
            if (push && can_push) begin
                data_q  <= push_data;
                valid_q <= 1'b1;
            end else if (accept) begin
                valid_q <= 1'b0;
            end
            if (clear) begin
                addr_q <= '0;
            end else if (accept) begin
                addr_q <= addr_q + 6'd1;
            end
        end
    end

endmodule

// File: rtl/track_recorder.sv
// Records live two-channel key events, timed in tempo ticks, as 24-bit track commands.
module track_recorder
    import tracker_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        arm,
    input  logic        stop,
    input  logic        tempo_tick,
    input  logic [1:0]  key_on,
    input  logic [1:0]  key_off,
    input  logic [3:0]  note_1,
    input  logic [3:0]  note_2,
    input  logic [1:0]  octave_1,
    input  logic [1:0]  octave_2,
    output logic        wr_valid,
    input  logic        wr_ready,
    output logic [5:0]  wr_addr,
    output logic [23:0] wr_data,
    output logic        recording,
    output logic        done,
    output logic        full,
    output logic        clipped
);

    rec_state_e  state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [3:0]  note1_q, note1_d, note2_q, note2_d;
    logic [1:0]  oct1_q, oct1_d, oct2_q, oct2_d;
    logic        end_sent_q, end_sent_d;
    logic        done_q, done_d;
    logic        full_q, full_d;
    logic        clipped_q, clipped_d;

    logic        push, push_end, clear, can_push, accept, drop;
    logic        close_write, open_note;
    logic [23:0] push_data, close_cmd;
    logic [5:0]  tick_n, n_sat, slot;
    logic [4:0]  dur;

    track_cmd_writer u_writer (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .push      (push),
        .push_data (push_data),
        .wr_ready  (wr_ready),
        .wr_valid  (wr_valid),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .can_push  (can_push),
        .accept    (accept),
        .drop      (drop)
    );

    // Segment length including a tick in the closing cycle, and the command that closes it
    always_comb begin
        tick_n    = cnt_q + {5'd0, tempo_tick};
        n_sat     = (tick_n > SEG_MAX) ? SEG_MAX : tick_n;
        dur       = (n_sat == 6'd0) ? 5'd0 : 5'(n_sat - 6'd1);
        close_cmd = (state_q == StRest)
                  ? pack_cmd(dur, 2'd0, NOTE_UNDEFINED, 2'd0, NOTE_UNDEFINED)
                  : pack_cmd(dur, oct2_q, note2_q, oct1_q, note1_q);
        // Entry a new command would occupy, counting one still waiting in the holding register
        slot      = wr_addr + {5'd0, wr_valid};
        push_data = push_end ? TRACK_END : close_cmd;
    end

    // Next-state, segment counting and write requests
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        note1_d     = note1_q;
        note2_d     = note2_q;
        oct1_d      = oct1_q;
        oct2_d      = oct2_q;
        end_sent_d  = end_sent_q;
        done_d      = 1'b0;
        full_d      = full_q;
        clipped_d   = clipped_q | drop;
        push        = 1'b0;
        push_end    = 1'b0;
        clear       = 1'b0;
        close_write = 1'b0;
        open_note   = 1'b0;

        case (state_q)
            StIdle, StDone: begin
                if (arm) begin
                    state_d   = StWait;
                    clear     = 1'b1;
                    cnt_d     = '0;
                    full_d    = 1'b0;
                    clipped_d = 1'b0;
                end
            end
            StWait: begin
                if (stop) begin
                    state_d    = StFinish;
                    end_sent_d = 1'b0;
                end else if (|key_on) begin
                    open_note = 1'b1;
                end
            end
            StNote: begin
                if (tempo_tick) begin
                    if (cnt_q == SEG_MAX) clipped_d = 1'b1;
                    else cnt_d = cnt_q + 6'd1;
                end
                if (stop) begin
                    close_write = 1'b1;
                    state_d     = StFinish;
                    end_sent_d  = 1'b0;
                end else if (|key_on) begin
                    // Retrigger, or key_off in the same cycle: the zero-length rest is dropped
                    close_write = 1'b1;
                    open_note   = 1'b1;
                end else if (|key_off) begin
                    close_write = 1'b1;
                    state_d     = StRest;
                    cnt_d       = '0;
                end
            end
            StRest: begin
                cnt_d = tick_n;
                if (stop) begin
                    close_write = (tick_n != 6'd0);
                    state_d     = StFinish;
                    end_sent_d  = 1'b0;
                end else if (|key_on) begin
                    close_write = (tick_n != 6'd0);
                    open_note   = 1'b1;
                end else if (tick_n == SEG_MAX) begin
                    // Long silences are split into back-to-back maximum-length rests
                    close_write = 1'b1;
                    cnt_d       = '0;
                end
            end
            StFinish: begin
                if (!end_sent_q) begin
                    if (can_push) begin
                        push       = 1'b1;
                        push_end   = 1'b1;
                        end_sent_d = 1'b1;
                    end
                end else if (accept) begin
                    state_d = StDone;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (open_note) begin
            state_d = StNote;
            cnt_d   = '0;
            note1_d = key_on[0] ? note_1 : NOTE_UNDEFINED;
            oct1_d  = key_on[0] ? octave_1 : 2'd0;
            note2_d = key_on[1] ? note_2 : NOTE_UNDEFINED;
            oct2_d  = key_on[1] ? octave_2 : 2'd0;
        end

        // A close landing on the reserved entry terminates the track there instead
        if (close_write) begin
            if (slot == LAST_ADDR) begin
                state_d    = StFinish;
                end_sent_d = 1'b0;
                full_d     = 1'b1;
            end else begin
                push = 1'b1;
            end
        end
    end

    // State and flag registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            note1_q    <= '0;
            note2_q    <= '0;
            oct1_q     <= '0;
            oct2_q     <= '0;
            end_sent_q <= 1'b0;
            done_q     <= 1'b0;
            full_q     <= 1'b0;
            clipped_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            note1_q    <= note1_d;
            note2_q    <= note2_d;
            oct1_q     <= oct1_d;
            oct2_q     <= oct2_d;
            end_sent_q <= end_sent_d;
            done_q     <= done_d;
            full_q     <= full_d;
            clipped_q  <= clipped_d;
        end
    end

    // Session status outputs
    always_comb begin
        recording = (state_q == StWait) || (state_q == StNote) ||
                    (state_q == StRest) || (state_q == StFinish);
        done      = done_q;
        full      = full_q;
        clipped   = clipped_q;
    end

endmodule

// File: tb/tb_track_recorder.sv
// Self-checking bench for track_recorder: directed scenarios plus randomized sessions
// checked against an event-level reference model of the recorded track.
module tb_track_recorder;

    logic        clk = 1'b0;
    logic        reset, arm, stop, tempo_tick, wr_ready;
    logic [1:0]  key_on, key_off, octave_1, octave_2;
    logic [3:0]  note_1, note_2;
    logic        wr_valid, recording, done, full, clipped;
    logic [5:0]  wr_addr;
    logic [23:0] wr_data;

    track_recorder dut (
        .clk        (clk),
        .reset      (reset),
        .arm        (arm),
        .stop       (stop),
        .tempo_tick (tempo_tick),
        .key_on     (key_on),
        .key_off    (key_off),
        .note_1     (note_1),
        .note_2     (note_2),
        .octave_1   (octave_1),
        .octave_2   (octave_2),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .recording  (recording),
        .done       (done),
        .full       (full),
        .clipped    (clipped)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Observed writes and done pulses, sampled mid-cycle
    logic [23:0] got_d[$];
    logic [5:0]  got_a[$];
    int          done_cnt = 0;
    logic        rec_at_done = 1'b1;

    always @(negedge clk) begin
        if (wr_valid && wr_ready) begin
            got_d.push_back(wr_data);
            got_a.push_back(wr_addr);
        end
        if (done) begin
            done_cnt++;
            rec_at_done = recording;
        end
    end

    // Reference model: whole-segment tick counts, commands derived when a segment ends
    localparam int M_IDLE = 0, M_WAIT = 1, M_NOTE = 2, M_REST = 3;
    int          m_st = M_IDLE;
    int          m_n = 0;
    logic [3:0]  m_n1, m_n2;
    logic [1:0]  m_o1, m_o2;
    bit          m_clip = 0;
    logic [23:0] exp_q[$];

    function automatic logic [23:0] mk(int d, logic [1:0] o2, logic [3:0] n2,
                                       logic [1:0] o1, logic [3:0] n1);
        logic [4:0] dd;
        dd = d[4:0];
        return {1'b0, 6'd0, dd, o2, n2, o1, n1};
    endfunction

    task automatic m_close_note();
        int d;
        d = (m_n == 0) ? 0 : ((m_n > 32) ? 31 : m_n - 1);
        if (m_n > 32 && exp_q.size() < 63) m_clip = 1;
        exp_q.push_back(mk(d, m_o2, m_n2, m_o1, m_n1));
    endtask

    task automatic m_close_rest();
        for (int k = 0; k < m_n / 32; k++) exp_q.push_back(mk(31, 2'd0, 4'hF, 2'd0, 4'hF));
        if (m_n % 32 != 0) exp_q.push_back(mk(m_n % 32 - 1, 2'd0, 4'hF, 2'd0, 4'hF));
    endtask

    task automatic m_open();
        m_n1 = key_on[0] ? note_1 : 4'hF;
        m_o1 = key_on[0] ? octave_1 : 2'd0;
        m_n2 = key_on[1] ? note_2 : 4'hF;
        m_o2 = key_on[1] ? octave_2 : 2'd0;
        m_n  = 0;
        m_st = M_NOTE;
    endtask

    task automatic model_step();
        if (reset) begin
            m_st = M_IDLE;
        end else begin
            case (m_st)
                M_IDLE: if (arm) begin m_st = M_WAIT; exp_q.delete(); m_clip = 0; end
                M_WAIT: begin
                    if (stop) begin exp_q.push_back(24'hFFFFFF); m_st = M_IDLE; end
                    else if (key_on != 2'b00) m_open();
                end
                M_NOTE: begin
                    m_n += int'(tempo_tick);
                    if (stop) begin
                        m_close_note(); exp_q.push_back(24'hFFFFFF); m_st = M_IDLE;
                    end else if (key_on != 2'b00) begin
                        m_close_note(); m_open();
                    end else if (key_off != 2'b00) begin
                        m_close_note(); m_st = M_REST; m_n = 0;
                    end
                end
                M_REST: begin
                    m_n += int'(tempo_tick);
                    if (stop) begin
                        m_close_rest(); exp_q.push_back(24'hFFFFFF); m_st = M_IDLE;
                    end else if (key_on != 2'b00) begin
                        m_close_rest(); m_open();
                    end
                end
                default: m_st = M_IDLE;
            endcase
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // One clock: model sees this cycle's inputs, pulses clear after the edge
    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
        arm = 0; stop = 0; tempo_tick = 0; key_on = 2'b00; key_off = 2'b00;
    endtask

    task automatic ticks(input int k);
        for (int i = 0; i < k; i++) begin
            tempo_tick = 1; cyc();
            cyc();
        end
    endtask

    task automatic start_session(input string tag);
        got_d.delete(); got_a.delete(); done_cnt = 0;
        arm = 1; cyc();
        chk({tag, ".recording_after_arm"}, {31'd0, recording}, 32'd1);
    endtask

    task automatic wait_done(input string tag);
        int k;
        k = 0;
        while (done_cnt == 0 && k < 200) begin cyc(); k++; end
        chk({tag, ".done_seen"}, {31'd0, done_cnt > 0}, 32'd1);
        cyc(); cyc();
        chk({tag, ".done_once"}, done_cnt, 32'd1);
        chk({tag, ".rec_low_at_done"}, {31'd0, rec_at_done}, 32'd0);
    endtask

    // Compare captured writes against the model track, applying the depth limit
    task automatic compare_session(input string tag);
        bit full_exp;
        int n;
        full_exp = 0;
        if (exp_q.size() >= 65) begin
            while (exp_q.size() > 63) void'(exp_q.pop_back());
            exp_q.push_back(24'hFFFFFF);
            full_exp = 1;
        end
        chk({tag, ".count"}, got_d.size(), exp_q.size());
        n = (got_d.size() < exp_q.size()) ? got_d.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s.addr%0d", tag, i), {26'd0, got_a[i]}, i);
            chk($sformatf("%s.data%0d", tag, i), {8'd0, got_d[i]}, {8'd0, exp_q[i]});
        end
        chk({tag, ".full"}, {31'd0, full}, {31'd0, full_exp});
        chk({tag, ".clipped"}, {31'd0, clipped}, {31'd0, m_clip});
    endtask

    initial begin
        logic [23:0] held;
        reset = 1; arm = 0; stop = 0; tempo_tick = 0; wr_ready = 1;
        key_on = 0; key_off = 0; note_1 = 0; note_2 = 0; octave_1 = 0; octave_2 = 0;
        cyc(); cyc();
        chk("rst.wr_valid", {31'd0, wr_valid}, 0);
        chk("rst.wr_addr", {26'd0, wr_addr}, 0);
        chk("rst.wr_data", {8'd0, wr_data}, 0);
        chk("rst.recording", {31'd0, recording}, 0);
        chk("rst.done", {31'd0, done}, 0);
        chk("rst.full", {31'd0, full}, 0);
        chk("rst.clipped", {31'd0, clipped}, 0);
        reset = 0; cyc();

        // Basic note / rest / two-channel note / stop
        start_session("t1");
        key_on = 2'b01; note_1 = 4'd7; octave_1 = 2'd1; cyc();
        ticks(9);
        key_off = 2'b01; cyc();
        ticks(8);
        key_on = 2'b11; note_1 = 4'd7; octave_1 = 2'd1; note_2 = 4'd3; octave_2 = 2'd2; cyc();
        ticks(1);
        stop = 1; cyc();
        wait_done("t1");
        compare_session("t1");
        chk("t1.n", got_d.size(), 4);
        if (got_d.size() >= 4) begin
            chk("t1.e0", {8'd0, got_d[0]}, 32'h0083D7);
            chk("t1.e1", {8'd0, got_d[1]}, 32'h0073CF);
            chk("t1.e2", {8'd0, got_d[2]}, 32'h0008D7);
            chk("t1.e3", {8'd0, got_d[3]}, 32'hFFFFFF);
        end

        // Long rest split into maximum rests; long note saturates and clips
        start_session("t2");
        key_on = 2'b01; note_1 = 4'd0; octave_1 = 2'd0; cyc();
        ticks(1);
        key_off = 2'b01; cyc();
        ticks(70);
        key_on = 2'b01; note_1 = 4'd11; octave_1 = 2'd3; cyc();
        ticks(40);
        stop = 1; cyc();
        wait_done("t2");
        compare_session("t2");
        chk("t2.n", got_d.size(), 6);
        if (got_d.size() >= 5) begin
            chk("t2.rest31", {8'd0, got_d[1]}, 32'h01F3CF);
            chk("t2.rest5", {8'd0, got_d[3]}, 32'h0053CF);
            chk("t2.note31", {8'd0, got_d[4]}, 32'h01F3FB);
        end
        chk("t2.clipped", {31'd0, clipped}, 1);

        // key_off and key_on together: consecutive notes, no rest entry
        start_session("t3");
        key_on = 2'b01; note_1 = 4'd4; octave_1 = 2'd2; cyc();
        ticks(3);
        key_on = 2'b01; key_off = 2'b01; note_1 = 4'd9; octave_1 = 2'd0; cyc();
        ticks(2);
        stop = 1; cyc();
        wait_done("t3");
        compare_session("t3");
        chk("t3.n", got_d.size(), 3);

        // Depth limit: entry 63 becomes the terminator, later events ignored
        start_session("t4");
        for (int i = 0; i < 70; i++) begin
            key_on = 2'b01; note_1 = 4'(i % 12); octave_1 = 2'(i % 4); cyc();
            tempo_tick = 1; cyc();
        end
        stop = 1; cyc();
        wait_done("t4");
        compare_session("t4");
        chk("t4.n", got_d.size(), 64);
        if (got_d.size() == 64) begin
            chk("t4.last_addr", {26'd0, got_a[63]}, 63);
            chk("t4.last_data", {8'd0, got_d[63]}, 32'hFFFFFF);
        end
        chk("t4.full", {31'd0, full}, 1);

        // Stalled write port: second close dropped, held command stable
        start_session("t5");
        wr_ready = 0;
        key_on = 2'b01; note_1 = 4'd2; octave_1 = 2'd3; cyc();
        ticks(2);
        key_off = 2'b01; cyc();
        held = wr_data;
        chk("t5.valid_rise", {31'd0, wr_valid}, 1);
        chk("t5.held_val", {8'd0, held}, 32'h0013F2);
        ticks(3);
        key_on = 2'b10; note_2 = 4'd5; octave_2 = 2'd1; cyc();
        for (int i = 0; i < 11; i++) begin
            chk($sformatf("t5.stable%0d", i), {7'd0, wr_valid, wr_data}, {7'd0, 1'b1, held});
            cyc();
        end
        chk("t5.clipped", {31'd0, clipped}, 1);
        wr_ready = 1; cyc();
        ticks(1);
        stop = 1; cyc();
        wait_done("t5");
        chk("t5.n", got_d.size(), 3);
        if (got_d.size() >= 3) begin
            chk("t5.e0", {8'd0, got_d[0]}, 32'h0013F2);
            chk("t5.e1", {8'd0, got_d[1]}, 32'h00054F);
            chk("t5.e2", {8'd0, got_d[2]}, 32'hFFFFFF);
        end

        // Reset while a write is pending aborts the session
        start_session("t6");
        key_on = 2'b01; note_1 = 4'd1; octave_1 = 2'd1; cyc();
        ticks(1);
        key_off = 2'b01; cyc();
        cyc();
        wr_ready = 0;
        tempo_tick = 1; cyc();
        key_on = 2'b01; cyc();
        chk("t6.pending", {31'd0, wr_valid}, 1);
        reset = 1; cyc();
        chk("t6.valid_drop", {31'd0, wr_valid}, 0);
        chk("t6.addr_clr", {26'd0, wr_addr}, 0);
        chk("t6.rec_low", {31'd0, recording}, 0);
        reset = 0; wr_ready = 1; cyc();
        start_session("t6b");
        key_on = 2'b01; note_1 = 4'd6; octave_1 = 2'd2; cyc();
        ticks(1);
        stop = 1; cyc();
        wait_done("t6b");
        compare_session("t6b");

        // Randomized sessions
        for (int s = 0; s < 3; s++) begin
            string tag;
            tag = $sformatf("rnd%0d", s);
            start_session(tag);
            for (int c = 0; c < 250; c++) begin
                int r;
                r = int'($urandom_range(0, 99));
                tempo_tick = ($urandom_range(0, 2) == 0);
                if (r < 6) begin
                    key_on   = 2'($urandom_range(1, 3));
                    note_1   = 4'($urandom_range(0, 11));
                    note_2   = 4'($urandom_range(0, 11));
                    octave_1 = 2'($urandom_range(0, 3));
                    octave_2 = 2'($urandom_range(0, 3));
                    if (r < 2) key_off = 2'($urandom_range(1, 3));
                end else if (r < 10) begin
                    key_off = 2'($urandom_range(1, 3));
                end
                cyc();
            end
            tempo_tick = ($urandom_range(0, 1) == 0);
            stop = 1; cyc();
            wait_done(tag);
            compare_session(tag);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/track_recorder.md
# track_recorder

Captures live two-channel key events (note, octave, key_on, key_off), timed in tempo ticks, and encodes them into the 24-bit track command format that the tracker plays back. It sits between the key-event source and the 64-entry track RAM, and writes commands through a valid/ready write port. Replaying the recorded track at the same tempo reproduces the input timing.

## Interface
- No parameters. Depth is fixed at 64 entries; duration is 5 bits.
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- arm  in  1  pulse: start a recording session (ignored unless IDLE/DONE)
- stop  in  1  pulse: close the open segment and terminate the track
- tempo_tick  in  1  one-cycle time base, same source as playback
- key_on  in  2  per-channel key-on pulses; bit0 = ch1, bit1 = ch2
- key_off  in  2  per-channel key-off pulses
- note_1, note_2  in  4  note codes, valid in the key_on cycle
- octave_1, octave_2  in  2  octaves, valid in the key_on cycle
- wr_valid  out  1  command write request
- wr_ready  in  1  RAM accepts the write
- wr_addr  out  6  entry index
- wr_data  out  24  command
- recording  out  1  session active
- done  out  1  one-cycle pulse after TRACK_END is accepted
- full  out  1  sticky: terminated by depth, not by stop
- clipped  out  1  sticky: note longer than 32 ticks, or write dropped

## Operation
- Command layout: [23] end flag, [16:12] duration, [11:10] octave_2, [9:6] note_2, [5:4] octave_1, [3:0] note_1. Bits [22:17] are 0. TRACK_END = 24'hFFFFFF.
- A command with duration d plays for d+1 tempo ticks. A recorded segment of n ticks is written with d = n−1.
- States:
  - IDLE: entered on reset.
  - WAIT: entered on arm. wr_addr is cleared and sticky flags are cleared. Leading silence is not recorded.
  - NOTE: entered on any key_on bit. Latches note and octave for the set bits. A channel whose key_on bit is 0 gets NOTE_UNDEFINED (4'hF) with octave 0. The tick count starts at 0.
  - REST: entered on any key_off bit from NOTE. Any key_off ends the segment for both channels.
  - FINISH: emits the closing command, if any, then TRACK_END.
  - DONE: terminal until the next arm.
- NOTE + key_on (retrigger): close the note and open a new NOTE.
- REST + key_on: close the rest and open a NOTE.
- Closing a segment: n = count of tempo_ticks inside the segment, including a tick in the closing cycle.
  - Note: written with d = max(n−1, 0).
  - Rest with n = 0: no command is written.
- Saturation:
  - NOTE: the count stops at 32 (d = 31) and clipped is set.
  - REST: when the count reaches 32, emit rest(31), reset the count to 0, and stay in REST.
- key_off and key_on in the same cycle: close the note. The resulting zero-length rest is dropped. Open the new NOTE.
- stop: from NOTE or REST, close the segment, then go to FINISH. From WAIT, write only TRACK_END.
- Depth: entries 0..62 hold commands and 63 is reserved. A close that would land at 63 instead writes TRACK_END there, sets full, and enters DONE.
- Output holding register is single-entry. If a segment closes while wr_valid is still pending, the new command is dropped and clipped is set. Counting continues unaffected.

## Timing
- Reset values: wr_valid 0, wr_addr 0, wr_data 0, recording 0, done 0, full 0, clipped 0, state IDLE.
- Reset mid-session aborts the session with no further writes. RAM contents are left as written.
- wr_valid rises the cycle after the closing event. wr_data and wr_addr stay stable until the handshake.
- A write completes in the cycle where wr_valid && wr_ready. wr_addr increments in the next cycle.
- recording goes high the cycle after arm. It goes low in the cycle done pulses.
- After stop, TRACK_END is presented no earlier than the cycle after the closing command is accepted.
- Throughput: one command per cycle when wr_ready is held high.

## Structure
- Shared package tracker_pkg holds:
  - NOTE_* codes (C = 0 … B = 11) and NOTE_UNDEFINED = 4'hF
  - TRACK_END
  - command field offsets
  - a cmd packing function, also used by playback
- Sub-module track_cmd_writer: one-entry valid/ready holding register plus the 6-bit address counter, with accept and drop reporting.

## Test plan
- arm; key_on=01 (note 7, octave 1); 9 ticks; key_off; 8 ticks; key_on=11; 1 tick; stop -> writes, in order:
  - addr0 {d8, ch2 F/0, ch1 oct1 note7}
  - addr1 rest(7)
  - addr2 d0 note
  - addr3 FFFFFF
  - then done pulses.
- Rest of 70 ticks -> rest(31), rest(31), rest(5). A note of 40 ticks -> d31 and clipped = 1.
- key_off and key_on in the same cycle -> no rest entry, and consecutive note entries.
- 64+ short notes -> entries 0..62 are notes, 63 = FFFFFF, full = 1, later events are ignored.
- wr_ready held low for 20 cycles across two closes -> the second command is dropped, clipped = 1, wr_data is unchanged until accepted.
- Reset asserted while wr_valid is high -> wr_valid drops next cycle, state returns to IDLE, and arm restarts at addr 0.
